// File: rtl/move_sequencer_pkg.sv
// Shared types and constants for the move sequencer slice.
package move_seq_pkg;

    localparam int unsigned N_AXES_DEFAULT = 5;
    localparam int unsigned TIMEOUT_W      = 32;

    localparam int unsigned AX_X  = 0;
    localparam int unsigned AX_Y  = 1;
    localparam int unsigned AX_Z  = 2;
    localparam int unsigned AX_E0 = 3;
    localparam int unsigned AX_E1 = 4;

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        SELECT,
        EXEC,
        DONE,
        ABORT
    } seq_state_t;

endpackage

// File: rtl/move_sequencer_if.sv
// Command, phase-start/done and status signals between the sequencer and its neighbours.
interface move_sequencer_if
    import move_seq_pkg::*;
#(
    parameter int unsigned N_AXES = N_AXES_DEFAULT,
    parameter int unsigned CNT_W  = 16
) ();

    logic              cmd_valid;
    logic              cmd_ready;
    logic [N_AXES-1:0] cmd_axis_mask;
    logic              abort;
    logic              calc_start;
    logic [N_AXES-1:0] calc_done;
    logic              sel_start;
    logic              sel_finish;
    logic [N_AXES-1:0] exec_start;
    logic [N_AXES-1:0] exec_done;
    logic              busy;
    logic              move_done;
    logic              timeout_err;
    logic [CNT_W-1:0]  move_count;

    // Sequencer side
    modport master (
        input  cmd_valid, cmd_axis_mask, abort, calc_done, sel_finish, exec_done,
        output cmd_ready, calc_start, sel_start, exec_start, busy, move_done,
               timeout_err, move_count
    );

    // Command source, calculators, selector and step generators
    modport slave (
        output cmd_valid, cmd_axis_mask, abort, calc_done, sel_finish, exec_done,
        input  cmd_ready, calc_start, sel_start, exec_start, busy, move_done,
               timeout_err, move_count
    );

endinterface

// File: rtl/move_sequencer_done_collector.sv
// Sticky per-axis completion tracker; all_done_c includes this cycle's done bits.
module done_collector
    import move_seq_pkg::*;
#(
    parameter int unsigned N_AXES = N_AXES_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              enable_i,
    input  logic [N_AXES-1:0] done_i,
    input  logic [N_AXES-1:0] mask_i,
    output logic              all_done_c
);

    logic [N_AXES-1:0] sticky_q;
    logic [N_AXES-1:0] sticky_d;

    always_comb begin
        sticky_d = sticky_q;
        if (clear_i) begin
            sticky_d = '0;
        end else if (enable_i) begin
            sticky_d = sticky_q | (done_i & mask_i);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sticky_q <= '0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign all_done_c = ((sticky_q | done_i) & mask_i) == mask_i;

endmodule

// File: rtl/move_sequencer.sv
// Sequences one move through calc -> select -> exec, holding level starts for the move's lifetime.
module move_sequencer
    import move_seq_pkg::*;
#(
    parameter int unsigned          N_AXES         = N_AXES_DEFAULT,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = 32'd50_000_000,
    parameter int unsigned          CNT_W          = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    move_sequencer_if.master        bus
);

    seq_state_t           state_q, state_d;
    logic [N_AXES-1:0]    mask_q, mask_d;
    logic [TIMEOUT_W-1:0] wdog_q, wdog_d;
    logic [CNT_W-1:0]     count_q, count_d;

    logic                 cmd_ready_q, busy_q, calc_start_q, sel_start_q;
    logic                 move_done_q, timeout_err_q;
    logic [N_AXES-1:0]    exec_start_q;

    logic                 accept_c, in_phase_c, wdog_expired_c, timeout_c;
    logic                 calc_all_done_c, exec_all_done_c;

    done_collector #(.N_AXES(N_AXES)) u_calc_collect (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (state_q != CALC),
        .enable_i   (state_q == CALC),
        .done_i     (bus.calc_done),
        .mask_i     (mask_q),
        .all_done_c (calc_all_done_c)
    );

    done_collector #(.N_AXES(N_AXES)) u_exec_collect (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (state_q != EXEC),
        .enable_i   (state_q == EXEC),
        .done_i     (bus.exec_done),
        .mask_i     (mask_q),
        .all_done_c (exec_all_done_c)
    );

    assign accept_c       = bus.cmd_valid && cmd_ready_q;
    assign in_phase_c     = state_q inside {CALC, SELECT, EXEC};
    assign wdog_expired_c = wdog_q == (TIMEOUT_CYCLES - TIMEOUT_W'(1));

    // Next state: abort beats phase exit, phase exit beats watchdog
    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        timeout_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    mask_d  = bus.cmd_axis_mask;
                    state_d = (bus.cmd_axis_mask == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (calc_all_done_c) begin
                    state_d = SELECT;
                end else if (wdog_expired_c) begin
                    state_d   = ABORT;
                    timeout_c = 1'b1;
                end
            end
            SELECT: begin
                if (bus.sel_finish) begin
                    state_d = EXEC;
                end else if (wdog_expired_c) begin
                    state_d   = ABORT;
                    timeout_c = 1'b1;
                end
            end
            EXEC: begin
                if (exec_all_done_c) begin
                    state_d = DONE;
                end else if (wdog_expired_c) begin
                    state_d   = ABORT;
                    timeout_c = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            ABORT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (in_phase_c && bus.abort) begin
            state_d   = ABORT;
            timeout_c = 1'b0;
        end
        wdog_d  = ((state_d != state_q) || !in_phase_c) ? '0 : wdog_q + TIMEOUT_W'(1);
        count_d = (state_d == DONE) ? count_q + CNT_W'(1) : count_q;
    end

    // Outputs are decoded from the next state so they line up with the state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            mask_q        <= '0;
            wdog_q        <= '0;
            count_q       <= '0;
            cmd_ready_q   <= 1'b0;
            busy_q        <= 1'b0;
            calc_start_q  <= 1'b0;
            sel_start_q   <= 1'b0;
            exec_start_q  <= '0;
            move_done_q   <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            mask_q        <= mask_d;
            wdog_q        <= wdog_d;
            count_q       <= count_d;
            cmd_ready_q   <= state_d == IDLE;
            busy_q        <= state_d != IDLE;
            calc_start_q  <= state_d inside {CALC, SELECT, EXEC};
            sel_start_q   <= state_d inside {SELECT, EXEC};
            exec_start_q  <= (state_d == EXEC) ? mask_d : '0;
            move_done_q   <= state_d == DONE;
            timeout_err_q <= timeout_c;
        end
    end

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.busy        = busy_q;
    assign bus.calc_start  = calc_start_q;
    assign bus.sel_start   = sel_start_q;
    assign bus.exec_start  = exec_start_q;
    assign bus.move_done   = move_done_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.move_count  = count_q;

endmodule

// File: tb/tb_move_sequencer.sv
// Directed bench for move_sequencer: cycle-exact output vectors with hand-derived expectations.
module tb_move_sequencer;

    localparam int unsigned N_AXES = 5;
    localparam int unsigned CNT_W  = 4;

    logic clk = 1'b0;
    logic reset;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    move_sequencer_if #(.N_AXES(N_AXES), .CNT_W(CNT_W)) bus ();

    move_sequencer #(
        .N_AXES         (N_AXES),
        .TIMEOUT_CYCLES (32'd8),
        .CNT_W          (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL sim_timeout: got no end, want $finish within 200us");
        $fatal(1, "simulation time limit");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {cmd_ready, busy, calc_start, sel_start, exec_start[4:0], move_done, timeout_err}
    function automatic logic [31:0] pk(input logic cr, input logic bz, input logic cs, input logic ss,
                                       input logic [4:0] es, input logic md, input logic te);
        return 32'({cr, bz, cs, ss, es, md, te});
    endfunction

    function automatic logic [31:0] outs();
        return 32'({bus.cmd_ready, bus.busy, bus.calc_start, bus.sel_start, bus.exec_start,
                    bus.move_done, bus.timeout_err});
    endfunction

    // Minimum-latency move with one-cycle responders; leaves cmd_valid high for back-to-back use
    task automatic run_move(input logic [4:0] m, input logic [CNT_W-1:0] cnt, input logic zt);
        logic z;
        z = 1'b0;
        bus.cmd_valid     = 1'b1;
        bus.cmd_axis_mask = m;
        tick();
        check_eq("mv_calc", outs(), pk(0, 1, 1, 0, 5'b0, 0, 0));
        z = zt & ~z;
        bus.calc_done = m | {2'b0, z, 2'b0};
        bus.exec_done = {2'b0, z, 2'b0};
        tick();
        check_eq("mv_sel", outs(), pk(0, 1, 1, 1, 5'b0, 0, 0));
        z = zt & ~z;
        bus.calc_done  = {2'b0, z, 2'b0};
        bus.exec_done  = {2'b0, z, 2'b0};
        bus.sel_finish = 1'b1;
        tick();
        check_eq("mv_exec", outs(), pk(0, 1, 1, 1, m, 0, 0));
        z = zt & ~z;
        bus.sel_finish = 1'b0;
        bus.calc_done  = {2'b0, z, 2'b0};
        bus.exec_done  = m | {2'b0, z, 2'b0};
        tick();
        check_eq("mv_done", outs(), pk(0, 1, 0, 0, 5'b0, 1, 0));
        check_eq("mv_count", 32'(bus.move_count), 32'(cnt));
        z = zt & ~z;
        bus.calc_done = {2'b0, z, 2'b0};
        bus.exec_done = {2'b0, z, 2'b0};
        tick();
        check_eq("mv_idle", outs(), pk(1, 0, 0, 0, 5'b0, 0, 0));
        bus.calc_done = '0;
        bus.exec_done = '0;
    endtask

    initial begin
        reset             = 1'b1;
        bus.cmd_valid     = 1'b0;
        bus.cmd_axis_mask = '0;
        bus.abort         = 1'b0;
        bus.calc_done     = '0;
        bus.sel_finish    = 1'b0;
        bus.exec_done     = '0;
        tick();
        tick();
        check_eq("rst_outs", outs(), pk(0, 0, 0, 0, 5'b0, 0, 0));
        check_eq("rst_count", 32'(bus.move_count), 32'd0);
        reset = 1'b0;
        tick();
        check_eq("post_rst", outs(), pk(1, 0, 0, 0, 5'b0, 0, 0));

        // Two axes with staggered calc completions and a delayed exec
        bus.cmd_valid     = 1'b1;
        bus.cmd_axis_mask = 5'b00011;
        tick();
        bus.cmd_valid     = 1'b0;
        bus.cmd_axis_mask = '0;
        for (int k = 1; k <= 5; k++) begin
            check_eq("t1_calc", outs(), pk(0, 1, 1, 0, 5'b0, 0, 0));
            bus.calc_done = (k == 2) ? 5'b00001 : (k == 5) ? 5'b00010 : 5'b00000;
            tick();
        end
        bus.calc_done = '0;
        check_eq("t1_sel", outs(), pk(0, 1, 1, 1, 5'b0, 0, 0));
        bus.sel_finish = 1'b1;
        tick();
        bus.sel_finish = 1'b0;
        for (int k = 7; k <= 10; k++) begin
            check_eq("t1_exec", outs(), pk(0, 1, 1, 1, 5'b00011, 0, 0));
            bus.exec_done = (k == 10) ? 5'b00011 : 5'b00000;
            tick();
        end
        bus.exec_done = '0;
        check_eq("t1_done", outs(), pk(0, 1, 0, 0, 5'b0, 1, 0));
        check_eq("t1_count", 32'(bus.move_count), 32'd1);
        tick();
        check_eq("t1_idle", outs(), pk(1, 0, 0, 0, 5'b0, 0, 0));

        // Zero-mask move completes one cycle after accept
        bus.cmd_valid     = 1'b1;
        bus.cmd_axis_mask = 5'b00000;
        tick();
        bus.cmd_valid = 1'b0;
        check_eq("t2_done", outs(), pk(0, 1, 0, 0, 5'b0, 1, 0));
        check_eq("t2_count", 32'(bus.move_count), 32'd2);
        tick();
        check_eq("t2_idle", outs(), pk(1, 0, 0, 0, 5'b0, 0, 0));

        // Calc never finishes: watchdog of 8 cycles fires
        bus.cmd_valid     = 1'b1;
        bus.cmd_axis_mask = 5'b00001;
        tick();
        bus.cmd_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            check_eq("t3_calc", outs(), pk(0, 1, 1, 0, 5'b0, 0, 0));
            tick();
        end
        check_eq("t3_tout", outs(), pk(0, 1, 0, 0, 5'b0, 0, 1));
        tick();
        check_eq("t3_idle", outs(), pk(1, 0, 0, 0, 5'b0, 0, 0));
        check_eq("t3_count", 32'(bus.move_count), 32'd2);

        // Abort coincides with the last exec_done
        bus.cmd_valid     = 1'b1;
        bus.cmd_axis_mask = 5'b00001;
        tick();
        bus.cmd_valid = 1'b0;
        check_eq("t4_calc", outs(), pk(0, 1, 1, 0, 5'b0, 0, 0));
        bus.calc_done = 5'b00001;
        tick();
        bus.calc_done = '0;
        check_eq("t4_sel", outs(), pk(0, 1, 1, 1, 5'b0, 0, 0));
        bus.sel_finish = 1'b1;
        tick();
        bus.sel_finish = 1'b0;
        check_eq("t4_exec", outs(), pk(0, 1, 1, 1, 5'b00001, 0, 0));
        bus.exec_done = 5'b00001;
        bus.abort     = 1'b1;
        tick();
        bus.exec_done = '0;
        bus.abort     = 1'b0;
        check_eq("t4_abort", outs(), pk(0, 1, 0, 0, 5'b0, 0, 0));
        check_eq("t4_count", 32'(bus.move_count), 32'd2);
        tick();
        check_eq("t4_idle", outs(), pk(1, 0, 0, 0, 5'b0, 0, 0));
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check_eq("t4_idle_abort", outs(), pk(1, 0, 0, 0, 5'b0, 0, 0));

        // Reset during EXEC drops every start on the next edge
        bus.cmd_valid     = 1'b1;
        bus.cmd_axis_mask = 5'b10001;
        tick();
        bus.cmd_valid = 1'b0;
        bus.calc_done = 5'b10001;
        tick();
        bus.calc_done  = '0;
        bus.sel_finish = 1'b1;
        tick();
        bus.sel_finish = 1'b0;
        check_eq("t5_exec", outs(), pk(0, 1, 1, 1, 5'b10001, 0, 0));
        reset = 1'b1;
        tick();
        check_eq("t5_rst", outs(), pk(0, 0, 0, 0, 5'b0, 0, 0));
        check_eq("t5_rst_count", 32'(bus.move_count), 32'd0);
        reset = 1'b0;
        tick();
        check_eq("t5_ready", outs(), pk(1, 0, 0, 0, 5'b0, 0, 0));

        // Back-to-back minimum moves; z toggles on done lines after the first; count wraps
        run_move(5'b00001, CNT_W'(1), 1'b0);
        for (int i = 2; i <= 17; i++) begin
            run_move(5'b00001, CNT_W'(i), 1'b1);
        end
        bus.cmd_valid = 1'b0;
        tick();
        check_eq("t6_idle", outs(), pk(1, 0, 0, 0, 5'b0, 0, 0));
        check_eq("t6_wrap", 32'(bus.move_count), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
